// File: rtl/interval_timer_ctrl_pkg.sv
// Shared state encoding and default sizing for the interval timer controller.
package interval_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int          DEF_WIDTH   = 32;
   localparam logic [31:0] DEF_TIMEOUT = 32'hFFFF_FFF0;

   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_ARMED = S_ARMED,
      ST_RUN   = S_RUN,
      ST_DONE  = S_DONE
   } state_t;

endpackage

// File: rtl/interval_timer_ctrl_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// Pulse appears 3 clk cycles after the input edge; identical for every instance.
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s3   <= 1'b0;
         rise <= 1'b0;
      end else begin
         s1   <= din;
         s2   <= s1;
         s3   <= s2;
         rise <= s2 & ~s3;
      end
   end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Arm / start / stop interval measurement with valid-ready result handoff.
// Optional RUN-state limit compiled in with INTERVAL_TIMER_TIMEOUT_EN.
module interval_timer_ctrl
   import interval_pkg::*;
#(
   parameter int               WIDTH   = DEF_WIDTH,
   parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(DEF_TIMEOUT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             arm,
   input  logic             abort,
   input  logic             start_in,
   input  logic             stop_in,
   input  logic             result_ready,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             timeout,
   output logic             armed,
   output logic             busy
);

   logic             start_rise;
   logic             stop_rise;
   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_nx;
   logic [WIDTH-1:0] count_inc;
   logic [WIDTH-1:0] result_nx;

   sync_edge u_start (.clk(clk), .reset(reset), .din(start_in), .rise(start_rise));
   sync_edge u_stop  (.clk(clk), .reset(reset), .din(stop_in),  .rise(stop_rise));

   assign count_inc = count + WIDTH'(1);

`ifdef INTERVAL_TIMER_TIMEOUT_EN
   logic tout_q;
   logic tout_nx;
   assign timeout = tout_q;
`else
   logic unused_timeout_param;
   assign unused_timeout_param = ^TIMEOUT;
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nx  = state;
      count_nx  = count;
      result_nx = result;
`ifdef INTERVAL_TIMER_TIMEOUT_EN
      tout_nx   = tout_q;
`endif
      // abort outranks every transition, including a same-cycle capture
      if (abort) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arm) state_nx = ST_ARMED;
            end
            ST_ARMED: begin
               if (start_rise) begin
                  state_nx = ST_RUN;
                  count_nx = '0;
               end
            end
            ST_RUN: begin
               if (stop_rise) begin
                  state_nx  = ST_DONE;
                  result_nx = count_inc;
`ifdef INTERVAL_TIMER_TIMEOUT_EN
                  tout_nx   = 1'b0;
               end else if (count_inc == TIMEOUT) begin
                  state_nx  = ST_DONE;
                  result_nx = TIMEOUT;
                  tout_nx   = 1'b1;
`endif
               end else begin
                  count_nx = count_inc;
               end
            end
            ST_DONE: begin
               if (result_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         count  <= '0;
         result <= '0;
`ifdef INTERVAL_TIMER_TIMEOUT_EN
         tout_q <= 1'b0;
`endif
      end else begin
         state  <= state_nx;
         count  <= count_nx;
         result <= result_nx;
`ifdef INTERVAL_TIMER_TIMEOUT_EN
         tout_q <= tout_nx;
`endif
      end
   end

   assign result_valid = (state == ST_DONE);
   assign armed        = (state == ST_ARMED);
   assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Randomised scoreboard bench for interval_timer_ctrl (small WIDTH so counter wrap is reachable).
module tb_interval_timer_ctrl;

   localparam int W   = 8;
   localparam int TMO = 40;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         arm = 1'b0;
   logic         abort = 1'b0;
   logic         start_in = 1'b0;
   logic         stop_in = 1'b0;
   logic         result_ready = 1'b0;
   logic [W-1:0] result;
   logic         result_valid;
   logic         timeout;
   logic         armed;
   logic         busy;

   typedef struct {
      logic [W-1:0] res;
      logic         tmo;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         mon_e;
   int           checks = 0;
   int           failures = 0;
   int           xfer_cnt = 0;
   logic         hold = 1'b0;
   logic [W-1:0] last_res = '0;
   logic         prev_valid = 1'b0;
   logic         prev_ready = 1'b0;
   logic         prev_xfer = 1'b0;
   logic [W-1:0] prev_result = '0;

   interval_timer_ctrl #(.WIDTH(W), .TIMEOUT(W'(TMO))) dut (
      .clk(clk), .reset(reset), .arm(arm), .abort(abort),
      .start_in(start_in), .stop_in(stop_in), .result_ready(result_ready),
      .result(result), .result_valid(result_valid), .timeout(timeout),
      .armed(armed), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: result is the start-to-stop distance in cycles, limited or wrapped.
   function automatic exp_t model(input int n);
      exp_t e;
`ifdef INTERVAL_TIMER_TIMEOUT_EN
      if (n > TMO) begin
         e.res = W'(TMO);
         e.tmo = 1'b1;
      end else begin
         e.res = W'(n);
         e.tmo = 1'b0;
      end
`else
      e.res = W'(n % (1 << W));
      e.tmo = 1'b0;
`endif
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         result_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
         prev_xfer  = 1'b0;
      end else begin
         if (prev_xfer) check("valid_drop_after_xfer", result_valid, 0);
         if (prev_valid && !prev_ready) begin
            check("stall_valid", result_valid, 1);
            check("stall_result", result, prev_result);
         end
         if (result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result: got %0d with none expected", result);
            end else begin
               mon_e = exp_q.pop_front();
               check("result", result, mon_e.res);
               check("timeout", timeout, mon_e.tmo);
               last_res = mon_e.res;
            end
            xfer_cnt++;
         end
         prev_valid  = result_valid;
         prev_ready  = result_ready;
         prev_xfer   = result_valid && result_ready;
         prev_result = result;
      end
   end

   task automatic wait_xfer(input int c0, input bit poke);
      for (int i = 0; i < 800; i++) begin
         arm = 1'b0;
         if (xfer_cnt != c0) return;
         if (poke && $urandom_range(0, 7) == 0) arm = 1'b1;
         tick();
      end
      arm = 1'b0;
      checks++;
      failures++;
      $display("FAIL xfer_timeout: got no transfer expected one within 800 cycles");
   endtask

   task automatic run_tx(input int n, input bit simul, input bit bp);
      int c0;
      bit seen;
      start_in = 1'b0;
      stop_in  = 1'b0;
      repeat (4) tick();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      check("armed_after_arm", armed, 1);
      c0 = xfer_cnt;
      exp_q.push_back(model(n));
      hold = bp;
      start_in = 1'b1;
      if (simul) begin
         stop_in = 1'b1;
         repeat (2) tick();
         stop_in = 1'b0;
         repeat (n - 2) tick();
      end else begin
         repeat (n) tick();
      end
      stop_in = 1'b1;
      if (bp) begin
         seen = 1'b0;
         for (int i = 0; i < 600 && !seen; i++) begin
            if (result_valid) seen = 1'b1;
            else tick();
         end
         check("bp_valid_seen", seen, 1);
         for (int i = 0; i < 50; i++) begin
            if (i == 5) begin
               start_in = 1'b0;
               stop_in  = 1'b0;
               arm      = 1'b1;
            end
            if (i == 6) arm = 1'b0;
            if (i == 8) begin
               start_in = 1'b1;
               stop_in  = 1'b1;
            end
            tick();
         end
         check("bp_valid_held", result_valid, 1);
         hold = 1'b0;
      end
      wait_xfer(c0, !bp);
      arm      = 1'b1;
      start_in = 1'b0;
      stop_in  = 1'b0;
      tick();
      arm = 1'b0;
      check("rearm_next_cycle", armed, 1);
   endtask

   task automatic abort_tx(input int k);
      start_in = 1'b0;
      stop_in  = 1'b0;
      repeat (4) tick();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      start_in = 1'b1;
      repeat (k) tick();
      check("busy_before_abort", busy, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_valid", result_valid, 0);
      check("abort_result_kept", result, last_res);
      stop_in = 1'b1;
      repeat (6) tick();
      check("abort_stays_idle", busy, 0);
   endtask

   initial begin
      int r;
      #12;
      check("rst_result", result, 0);
      check("rst_valid", result_valid, 0);
      check("rst_timeout", timeout, 0);
      check("rst_armed", armed, 0);
      check("rst_busy", busy, 0);
      #3 reset = 1'b1;
      repeat (2) tick();

      run_tx(100, 1'b0, 1'b0);
      run_tx(7, 1'b1, 1'b0);
      run_tx(30, 1'b0, 1'b1);
      abort_tx(20);
      run_tx(258, 1'b0, 1'b0);
      run_tx(TMO, 1'b0, 1'b0);
      run_tx(TMO + 1, 1'b0, 1'b0);
      run_tx(1, 1'b0, 1'b0);
      run_tx(256, 1'b0, 1'b0);

      for (int t = 0; t < 20; t++) begin
         r = $urandom_range(0, 4);
         case (r)
            0: abort_tx($urandom_range(5, 30));
            1: run_tx($urandom_range(4, 300), 1'b1, 1'b0);
            2: run_tx($urandom_range(1, 300), 1'b0, 1'b1);
            default: run_tx($urandom_range(1, 300), 1'b0, 1'b0);
         endcase
      end

      // Reset asserted in the middle of a measurement
      start_in = 1'b0;
      stop_in  = 1'b0;
      repeat (4) tick();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      start_in = 1'b1;
      repeat (10) tick();
      check("pre_reset_busy", busy, 1);
      #2 reset = 1'b0;
      #1;
      check("midrun_rst_busy", busy, 0);
      check("midrun_rst_armed", armed, 0);
      check("midrun_rst_valid", result_valid, 0);
      check("midrun_rst_result", result, 0);
      check("midrun_rst_timeout", timeout, 0);
      last_res = '0;
      #3 reset = 1'b1;
      start_in = 1'b0;
      repeat (2) tick();
      check("post_rst_idle", busy, 0);
      repeat (3) tick();
      start_in = 1'b1;
      stop_in  = 1'b1;
      repeat (8) tick();
      check("post_rst_needs_arm", busy, 0);
      run_tx(100, 1'b0, 1'b0);

      repeat (10) tick();
      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/interval_timer_ctrl.md
# interval_timer_ctrl

Controller that sequences the free-running cycle counter into a time-interval measurement. It arms on command, synchronises two external edge inputs, runs the counter between a start edge and a stop edge, and hands the captured cycle count to the readout logic over a valid/ready handshake. It sits between the board-level timing inputs and the host readout path on the Spartan-6 design.

## Interface
- WIDTH, 32: counter and result width in bits.
- TIMEOUT, 32'hFFFF_FFF0: RUN-state cycle limit; used only when the timeout feature is compiled in; must be ≥ 1 and ≤ 2^WIDTH−1.
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- arm  in  1  synchronous pulse; arms a measurement from IDLE.
- abort  in  1  synchronous; returns to IDLE from any state, discards in-flight count.
- start_in  in  1  asynchronous external start signal; rising edge starts the interval.
- stop_in  in  1  asynchronous external stop signal; rising edge ends the interval.
- result_ready  in  1  readout accepts result.
- result  out  WIDTH  captured interval in clk cycles.
- result_valid  out  1  result available.
- timeout  out  1  qualifies result: 1 = measurement aborted by timeout.
- armed  out  1  high in ARMED.
- busy  out  1  high in ARMED, RUN or DONE.

## Operation
- start_in/stop_in: each through a 2-FF synchroniser plus registered rising-edge detect, producing start_rise/stop_rise single-cycle pulses.
- States: IDLE, ARMED, RUN, DONE.
- IDLE: arm=1 -> ARMED. Edges ignored.
- ARMED: start_rise -> RUN, count <= 0. stop_rise alone ignored. start_rise and stop_rise in same cycle: start honoured, stop ignored.
- RUN: each cycle without stop_rise, count <= count+1. stop_rise -> result <= count+1, timeout <= 0, DONE. start_rise ignored.
- Result equals number of clk cycles between the start_rise cycle and the stop_rise cycle (≥ 1).
- DONE: result_valid=1. Transfer occurs on result_valid & result_ready; next state IDLE. result and timeout hold their values until next capture.
- arm outside IDLE: ignored.
- abort=1: -> IDLE next cycle from any state, result_valid drops, result unchanged. abort has priority over every other transition including capture.
- Reset values: state IDLE, count 0, result 0, result_valid 0, timeout 0, armed 0, busy 0, synchroniser and edge-detect flops 0.

## Timing
- Input edge to start_rise/stop_rise: 3 clk cycles (2 sync + 1 detect). Equal for both inputs, so the interval measurement carries no systematic offset, ±1 cycle quantisation.
- stop_rise cycle -> result_valid high on next cycle.
- result_ready may be high before result_valid. Transfer completes in the first valid cycle. Minimum DONE dwell is 1 cycle.
- IDLE after transfer: arm accepted on the very next cycle.
- reset deasserted asynchronously by the board. Outputs are not assumed valid until 2 cycles after release.

## Configuration
- INTERVAL_TIMER_TIMEOUT_EN defined:
  - In RUN, when count+1 reaches TIMEOUT without stop_rise, go to DONE with result <= TIMEOUT and timeout <= 1.
  - If stop_rise arrives in the same cycle, the stop capture wins and timeout stays 0.
- Not defined:
  - No limit. count wraps modulo 2^WIDTH.
  - timeout output tied 0.
  - TIMEOUT parameter unused.

## Structure
- Shared package interval_pkg:
  - State encoding localparams S_IDLE=2'd0, S_ARMED=2'd1, S_RUN=2'd2, S_DONE=2'd3.
  - Default WIDTH and TIMEOUT constants.
- One sub-module: sync_edge.
  - 2-FF synchroniser plus rising-edge detect, with async active-low reset.
  - Instantiated twice, once for start_in and once for stop_in.
- Counter, FSM and result register live in interval_timer_ctrl.

## Test plan
- Reset behaviour: reset low mid-RUN -> all outputs 0 immediately. After release, state IDLE and arm required again.
- Basic interval: arm, start_in rises, stop_in rises 100 clk later -> result=100, result_valid=1, timeout=0. Ready high -> valid drops in 1 cycle.
- Simultaneous edges:
  - start_in and stop_in rise together in ARMED -> stays RUN.
  - Second stop 7 cycles later -> result=7.
- Back-pressure and re-arm:
  - Hold result_ready=0 for 50 cycles -> result_valid and result stable throughout.
  - arm and edges during DONE ignored.
  - After transfer, arm accepted on the next cycle.
- Abort in RUN after 20 cycles -> IDLE next cycle, result_valid stays 0, previous result unchanged.
- Timeout:
  - With INTERVAL_TIMER_TIMEOUT_EN and TIMEOUT=16, no stop -> result=16, timeout=1 on the 16th RUN cycle.
  - Without the macro and WIDTH=4, stop after 18 cycles -> result=2.
